// File: rtl/tt_eval_seq.sv
// rtl/tt_eval_seq.sv - run-time reloadable truth-table evaluator with serial load and exhaustive sweep
module tt_eval_seq #(
    parameter int                       N_IN       = 3,
    parameter logic [(1 << N_IN) - 1:0] DEFAULT_TT = 8'h9A
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [N_IN - 1:0]    in,
    output logic                 f,
    output logic                 f_valid,
    input  logic                 load_start,
    input  logic                 cfg_en,
    input  logic                 cfg_bit,
    output logic                 load_done,
    input  logic                 sweep_start,
    output logic [(1 << N_IN) - 1:0] sweep_vec,
    output logic [N_IN:0]        ones_cnt,
    output logic                 sweep_done,
    output logic                 busy
);

    localparam int             TT_W    = 1 << N_IN;
    localparam logic [N_IN:0]  CNT_END = (N_IN + 1)'(TT_W);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SWEEP = 2'd2;

    logic [1:0]         state;
    logic [TT_W - 1:0]  tt;
    logic [TT_W - 1:0]  shadow;
    // One counter serves as the load bit counter and the sweep index; the
    // extra MSB lets "all 2^N_IN positions done" be seen without wrapping.
    logic [N_IN:0]      cnt;
    logic [N_IN - 1:0]  pos;

    assign pos  = cnt[N_IN - 1:0];
    assign busy = (state == ST_LOAD) || (state == ST_SWEEP);

    // Mode sequencing and the shared load/sweep counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        state <= ST_LOAD;
                        cnt   <= '0;
                    end else if (sweep_start) begin
                        state <= ST_SWEEP;
                        cnt   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (cnt == CNT_END) begin
                        state <= ST_IDLE;
                    end else if (cfg_en) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (cnt == CNT_END) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Shadow fill during load; the active table only changes in one commit step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt        <= DEFAULT_TT;
            shadow    <= '0;
            load_done <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (state == ST_LOAD) begin
                if (cnt == CNT_END) begin
                    tt        <= shadow;
                    load_done <= 1'b1;
                end else if (cfg_en) begin
                    shadow[pos] <= cfg_bit;
                end
            end
        end
    end

    // Single-cycle evaluation from IDLE; F holds between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f       <= 1'b0;
            f_valid <= 1'b0;
        end else begin
            f_valid <= 1'b0;
            if (state == ST_IDLE && !load_start && !sweep_start && in_valid) begin
                f       <= tt[in];
                f_valid <= 1'b1;
            end
        end
    end

    // Sweep capture of the response vector and its minterm count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_vec  <= '0;
            ones_cnt   <= '0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            if (state == ST_IDLE && !load_start && sweep_start) begin
                sweep_vec <= '0;
                ones_cnt  <= '0;
            end else if (state == ST_SWEEP) begin
                if (cnt == CNT_END) begin
                    sweep_done <= 1'b1;
                end else begin
                    sweep_vec[pos] <= tt[pos];
                    ones_cnt       <= ones_cnt + {{N_IN{1'b0}}, tt[pos]};
                end
            end
        end
    end

endmodule
